// File: rtl/polygon_feeder.sv
// rtl/polygon_feeder.sv - walks a wall-quad display list, culls off-screen quads, feeds draw_polygon
// One quad is in flight at a time; the next fetch waits for draw_polygon's done.
module polygon_feeder #(
  parameter int CORDW = 16,
  parameter int IDXW  = 6,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [IDXW:0]           n_quads,
  output logic [IDXW-1:0]         rd_addr,
  input  logic [8*CORDW-1:0]      rd_data,
  output logic signed [CORDW-1:0] x0,
  output logic signed [CORDW-1:0] y0,
  output logic signed [CORDW-1:0] x1,
  output logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x2,
  output logic signed [CORDW-1:0] y2,
  output logic signed [CORDW-1:0] x3,
  output logic signed [CORDW-1:0] y3,
  output logic                    poly_start,
  input  logic                    poly_done,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_CULL,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic signed [CORDW-1:0] H_LIM   = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] V_LIM   = CORDW'(V_RES);
  localparam logic [IDXW-1:0]         IDX_ONE = IDXW'(1);
  localparam logic [IDXW:0]           CNT_ONE = (IDXW+1)'(1);

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [IDXW:0]           count_q, count_d;
  logic [IDXW-1:0]         rd_addr_q, rd_addr_d;
  logic                    poly_start_q, poly_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic signed [CORDW-1:0] vx_q [4];
  logic signed [CORDW-1:0] vx_d [4];
  logic signed [CORDW-1:0] vy_q [4];
  logic signed [CORDW-1:0] vy_d [4];

  logic all_xl, all_xh, all_yl, all_yh;
  logic reject, is_last, advance;
  logic [IDXW-1:0] idx_next;

  // Trivial reject: every vertex beyond the same screen edge.
  always_comb begin
    all_xl = 1'b1;
    all_xh = 1'b1;
    all_yl = 1'b1;
    all_yh = 1'b1;
    for (int i = 0; i < 4; i++) begin
      all_xl = all_xl & vx_q[i][CORDW-1];
      all_xh = all_xh & (vx_q[i] >= H_LIM);
      all_yl = all_yl & vy_q[i][CORDW-1];
      all_yh = all_yh & (vy_q[i] >= V_LIM);
    end
    reject = all_xl | all_xh | all_yl | all_yh;
  end

  assign is_last  = ({1'b0, idx_q} == (count_q - CNT_ONE));
  assign idx_next = idx_q + IDX_ONE;
  assign advance  = ((state_q == S_CULL) && reject) || ((state_q == S_WAIT) && poly_done);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    rd_addr_d    = rd_addr_q;
    poly_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    vx_d         = vx_q;
    vy_d         = vy_q;

    if (frame_start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          count_d   = n_quads;
          overrun_d = 1'b0;
          if (n_quads == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d     = '0;
            rd_addr_d = '0;
            busy_d    = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        for (int i = 0; i < 4; i++) begin
          vx_d[i] = rd_data[(8-2*i)*CORDW-1 -: CORDW];
          vy_d[i] = rd_data[(7-2*i)*CORDW-1 -: CORDW];
        end
        state_d = S_CULL;
      end
      S_CULL: begin
        if (!reject) begin
          state_d      = S_START;
          poly_start_d = 1'b1;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  state_d = S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared by culled quads and finished draws; idx stops at the last quad.
    if (advance) begin
      if (is_last) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        idx_d     = idx_next;
        rd_addr_d = idx_next;
        state_d   = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      rd_addr_q    <= '0;
      poly_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      rd_addr_q    <= rd_addr_d;
      poly_start_q <= poly_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign poly_start = poly_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign x0 = vx_q[0];
  assign y0 = vy_q[0];
  assign x1 = vx_q[1];
  assign y1 = vy_q[1];
  assign x2 = vx_q[2];
  assign y2 = vy_q[2];
  assign x3 = vx_q[3];
  assign y3 = vy_q[3];

endmodule

// File: tb/tb_polygon_feeder.sv
// tb/tb_polygon_feeder.sv - directed self-checking bench for polygon_feeder
module tb_polygon_feeder;
  localparam int CORDW = 16;
  localparam int IDXW  = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    frame_start;
  logic [IDXW:0]           n_quads;
  logic [IDXW-1:0]         rd_addr;
  logic [8*CORDW-1:0]      rd_data;
  logic signed [CORDW-1:0] x0, y0, x1, y1, x2, y2, x3, y3;
  logic                    poly_start, poly_done, busy, done, overrun;

  logic [8*CORDW-1:0] mem [0:63];

  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int s0;
  logic busy_seen = 1'b0;
  logic [IDXW-1:0] start_addrs [$];

  polygon_feeder #(.CORDW(CORDW), .IDXW(IDXW), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .n_quads(n_quads),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .poly_start(poly_start), .poly_done(poly_done),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic logic [8*CORDW-1:0] quad(input int a, b, c, d, e, f, g, h);
    return {CORDW'(a), CORDW'(b), CORDW'(c), CORDW'(d), CORDW'(e), CORDW'(f), CORDW'(g), CORDW'(h)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (poly_start) begin
      start_cnt++;
      start_addrs.push_back(rd_addr);
    end
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_frame(input int n);
    n_quads = (IDXW+1)'(n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int b;
    b = 0;
    do begin
      tick();
      b++;
    end while (!poly_start && b < 60);
    if (!poly_start) check_eq({tag, " start timeout"}, poly_start, 1);
  endtask

  task automatic finish_quad(input int delay);
    ticks(delay);
    poly_done = 1'b1;
    tick();
    poly_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    frame_start = 1'b0;
    poly_done = 1'b0;
    n_quads = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    ticks(2);
    check_eq("reset flags", {busy, done, overrun, poly_start}, 4'b0000);
    check_eq("reset rd_addr", rd_addr, 0);
    check_eq("reset x0", x0, 0);
    check_eq("reset y3", y3, 0);
    rst = 1'b1;
    tick();

    // single quad, exact latency
    mem[0] = quad(10, 10, 100, 10, 100, 80, 10, 80);
    s0 = start_cnt;
    pulse_frame(1);
    check_eq("t1 busy", busy, 1);
    check_eq("t1 rd_addr", rd_addr, 0);
    ticks(2);
    check_eq("t1 no early start", poly_start, 0);
    tick();
    check_eq("t1 start cycle4", poly_start, 1);
    check_eq("t1 x0", x0, 10);
    check_eq("t1 y2", y2, 80);
    ticks(10);
    check_eq("t1 x1 stable", x1, 100);
    finish_quad(10);
    check_eq("t1 done", done, 1);
    check_eq("t1 busy low", busy, 0);
    tick();
    check_eq("t1 done pulse", done, 0);
    check_eq("t1 starts", start_cnt - s0, 1);

    // middle quad off the left edge
    mem[1] = quad(-50, 0, -5, 0, -20, 50, -10, 50);
    mem[2] = quad(200, 10, 300, 10, 300, 90, 200, 90);
    start_addrs.delete();
    s0 = start_cnt;
    pulse_frame(3);
    wait_start("t2a");
    check_eq("t2 first x0", x0, 10);
    finish_quad(3);
    wait_start("t2b");
    check_eq("t2 second x0", x0, 200);
    finish_quad(3);
    check_eq("t2 done", done, 1);
    check_eq("t2 starts", start_cnt - s0, 2);
    check_eq("t2 addr count", start_addrs.size(), 2);
    if (start_addrs.size() == 2) begin
      check_eq("t2 addr a", start_addrs[0], 0);
      check_eq("t2 addr b", start_addrs[1], 2);
    end
    tick();

    // screen-edge boundaries
    mem[0] = quad(640, 10, 700, 10, 700, 80, 640, 80);
    mem[1] = quad(639, 10, 700, 10, 700, 80, 640, 80);
    mem[2] = quad(10, -1, 100, -1, 100, -30, 10, -30);
    mem[3] = quad(10, 480, 100, 480, 100, 500, 10, 500);
    mem[4] = quad(10, 479, 100, 500, 100, 500, 10, 500);
    start_addrs.delete();
    s0 = start_cnt;
    pulse_frame(5);
    wait_start("t7a");
    finish_quad(2);
    wait_start("t7b");
    finish_quad(2);
    check_eq("t7 done", done, 1);
    check_eq("t7 starts", start_cnt - s0, 2);
    if (start_addrs.size() == 2) begin
      check_eq("t7 addr a", start_addrs[0], 1);
      check_eq("t7 addr b", start_addrs[1], 4);
    end
    tick();

    // empty list
    busy_seen = 1'b0;
    s0 = start_cnt;
    pulse_frame(0);
    check_eq("t3 done cycle1", done, 1);
    check_eq("t3 rd_addr held", rd_addr, 4);
    tick();
    check_eq("t3 done pulse", done, 0);
    ticks(3);
    check_eq("t3 busy never", busy_seen, 0);
    check_eq("t3 no starts", start_cnt - s0, 0);

    // overrun during WAIT
    mem[0] = quad(10, 10, 100, 10, 100, 80, 10, 80);
    s0 = start_cnt;
    pulse_frame(1);
    wait_start("t4");
    ticks(2);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("t4 overrun", overrun, 1);
    finish_quad(3);
    check_eq("t4 done", done, 1);
    check_eq("t4 starts", start_cnt - s0, 1);
    tick();
    pulse_frame(0);
    check_eq("t4 overrun cleared", overrun, 0);
    tick();

    // full list, no wrap
    for (int i = 0; i < 64; i++) mem[i] = quad(i, 5, i + 50, 5, i + 50, 60, i, 60);
    start_addrs.delete();
    s0 = start_cnt;
    pulse_frame(64);
    for (int i = 0; i < 64; i++) begin
      wait_start("t6");
      check_eq("t6 rd_addr", rd_addr, i);
      check_eq("t6 x0", x0, i);
      finish_quad(1);
    end
    check_eq("t6 done", done, 1);
    check_eq("t6 starts", start_cnt - s0, 64);
    tick();
    check_eq("t6 idle", {busy, done}, 2'b00);

    // async reset while waiting
    mem[0] = quad(10, 10, 100, 10, 100, 80, 10, 80);
    pulse_frame(1);
    wait_start("t5");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    ticks(2);
    #2 rst = 1'b0;
    #1;
    check_eq("t5 async flags", {busy, done, overrun, poly_start}, 4'b0000);
    check_eq("t5 async rd_addr", rd_addr, 0);
    check_eq("t5 async x0", x0, 0);
    check_eq("t5 async y2", y2, 0);
    tick();
    s0 = start_cnt;
    rst = 1'b1;
    poly_done = 1'b1;
    tick();
    poly_done = 1'b0;
    ticks(10);
    check_eq("t5 no start", start_cnt - s0, 0);
    check_eq("t5 quiet", {busy, done}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
